// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the data stage.
// MEM has fixed priority over IF, a branch flush cancels a fetch, and per-stage stalls are generated here.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_done,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,
  output logic          port_req,
  output logic          port_we,
  output logic [AW-1:0] port_addr,
  output logic [DW-1:0] port_wdata,
  input  logic          port_ready,
  input  logic [DW-1:0] port_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   grant_if, grant_mem;
  logic   if_done_nxt, mem_done_nxt;

  // A requester whose done pulse is high still shows its old request, so it is masked.
  always_comb begin
    state_nxt    = state;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;
    if_done_nxt  = 1'b0;
    mem_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && !mem_done) begin
          grant_mem = 1'b1;
          state_nxt = BUSY_MEM;
        end else if (if_req && !if_done && !if_flush) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (port_ready) begin
          state_nxt   = IDLE;
          if_done_nxt = !if_flush;
        end else if (if_flush) begin
          state_nxt = DRAIN;
        end
      end
      BUSY_MEM: begin
        if (port_ready) begin
          state_nxt    = IDLE;
          mem_done_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (port_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      port_req   <= 1'b0;
      port_we    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      port_req <= (state_nxt != IDLE);
      if_done  <= if_done_nxt;
      mem_done <= mem_done_nxt;
      if (grant_mem) begin
        port_addr  <= mem_addr;
        port_we    <= mem_we;
        port_wdata <= mem_wdata;
      end else if (grant_if) begin
        port_addr <= if_addr;
        port_we   <= 1'b0;
      end
      if (if_done_nxt) begin
        if_rdata <= port_rdata;
      end
      // Store completions leave the previous load data in place.
      if (mem_done_nxt && !port_we) begin
        mem_rdata <= port_rdata;
      end
    end
  end

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is compared every cycle,
// and each scenario also pins hand-computed values at specific cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_done, mem_done, if_stall, mem_stall;
  logic [31:0] if_rdata, mem_rdata;
  logic        port_req, port_we, port_ready;
  logic [31:0] port_addr, port_wdata, port_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int rcnt = 0;
  int acc_cnt = 0;
  int if_done_cnt = 0;
  logic [31:0] last_acc_addr = '0;
  bit mon_en = 1'b0;

  // transaction-level model state
  bit          m_busy = 0, m_mem = 0, m_cancel = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  bit          e_if_done = 0, e_mem_done = 0;
  logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ready(port_ready), .port_rdata(port_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory responder: ready after lat cycles of port_req, data only valid with ready.
  always @(posedge clk) begin
    #1;
    if (port_req) begin
      rcnt = rcnt + 1;
      if (rcnt == lat) begin
        port_ready    = 1'b1;
        port_rdata    = rd_of(port_addr);
        last_acc_addr = port_addr;
        acc_cnt++;
      end else begin
        port_ready = 1'b0;
        port_rdata = 32'hBAD0_0BAD;
      end
    end else begin
      rcnt       = 0;
      port_ready = 1'b0;
      port_rdata = 32'hBAD0_0BAD;
    end
  end

  // Model: one outstanding port transaction, optionally cancelled by a fetch flush.
  always @(posedge clk) begin
    bit nd_if, nd_mem;
    nd_if  = 0;
    nd_mem = 0;
    if (!rstn) begin
      m_busy = 0; m_mem = 0; m_cancel = 0; m_we = 0;
      m_addr = '0; m_wdata = '0;
      e_if_rdata = '0; e_mem_rdata = '0;
    end else if (m_busy) begin
      if (!m_mem && if_flush) m_cancel = 1;
      if (port_ready) begin
        m_busy = 0;
        if (m_mem) begin
          nd_mem = 1;
          if (!m_we) e_mem_rdata = port_rdata;
        end else if (!m_cancel) begin
          nd_if = 1;
          e_if_rdata = port_rdata;
        end
      end
    end else if (mem_req && !e_mem_done) begin
      m_busy = 1; m_mem = 1; m_cancel = 0;
      m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
    end else if (if_req && !e_if_done && !if_flush) begin
      m_busy = 1; m_mem = 0; m_cancel = 0;
      m_addr = if_addr; m_we = 0;
    end
    e_if_done  = nd_if;
    e_mem_done = nd_mem;
  end

  always @(negedge clk) begin
    if (if_done === 1'b1) if_done_cnt++;
    if (mon_en) begin
      chk("m_port_req", {31'b0, port_req}, {31'b0, m_busy});
      chk("m_if_done", {31'b0, if_done}, {31'b0, e_if_done});
      chk("m_mem_done", {31'b0, mem_done}, {31'b0, e_mem_done});
      chk("m_if_rdata", if_rdata, e_if_rdata);
      chk("m_mem_rdata", mem_rdata, e_mem_rdata);
      chk("m_if_stall", {31'b0, if_stall}, {31'b0, if_req & ~e_if_done});
      chk("m_mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~e_mem_done});
      if (m_busy) begin
        chk("m_port_addr", port_addr, m_addr);
        chk("m_port_we", {31'b0, port_we}, {31'b0, m_we});
        if (m_we) chk("m_port_wdata", port_wdata, m_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n, dcyc, prev, d0;
    logic [31:0] fa;
    rstn = 1'b0; if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    port_ready = 0; port_rdata = 32'hBAD0_0BAD;
    repeat (2) tick();
    chk("rst_port_req", {31'b0, port_req}, 32'd0);
    chk("rst_port_we", {31'b0, port_we}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_mem_done", {31'b0, mem_done}, 32'd0);
    chk("rst_port_addr", port_addr, 32'd0);
    chk("rst_port_wdata", port_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;
    tick();

    // single fetch, ready in cycle 3
    lat = 3; if_req = 1; if_addr = 32'h100;
    #1 chk("t1_stall_c0", {31'b0, if_stall}, 32'd1);
    tick();
    chk("t1_preq_c1", {31'b0, port_req}, 32'd1);
    chk("t1_addr_c1", port_addr, 32'h100);
    chk("t1_we_c1", {31'b0, port_we}, 32'd0);
    tick(); tick();
    chk("t1_preq_c3", {31'b0, port_req}, 32'd1);
    chk("t1_stall_c3", {31'b0, if_stall}, 32'd1);
    tick();
    chk("t1_done_c4", {31'b0, if_done}, 32'd1);
    chk("t1_rdata_c4", if_rdata, 32'h0050_0093);
    chk("t1_preq_c4", {31'b0, port_req}, 32'd0);
    chk("t1_stall_c4", {31'b0, if_stall}, 32'd0);
    tick(); if_req = 0;
    tick(); tick();

    // simultaneous store and fetch, MEM first
    lat = 1; a0 = acc_cnt;
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t2_preq_c1", {31'b0, port_req}, 32'd1);
    chk("t2_we_c1", {31'b0, port_we}, 32'd1);
    chk("t2_addr_c1", port_addr, 32'h2000);
    chk("t2_wdata_c1", port_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t2_mdone_c2", {31'b0, mem_done}, 32'd1);
    chk("t2_preq_c2", {31'b0, port_req}, 32'd0);
    tick(); mem_req = 0; mem_we = 0;
    chk("t2_preq_c3", {31'b0, port_req}, 32'd1);
    chk("t2_addr_c3", port_addr, 32'h104);
    chk("t2_we_c3", {31'b0, port_we}, 32'd0);
    chk("t2_mdone_c3", {31'b0, mem_done}, 32'd0);
    tick();
    chk("t2_idone_c4", {31'b0, if_done}, 32'd1);
    chk("t2_irdata_c4", if_rdata, 32'h0104_C0DE);
    tick(); if_req = 0;
    tick();
    chk("t2_accesses", acc_cnt - a0, 32'd2);
    chk("t2_mrdata_kept", mem_rdata, 32'd0);
    tick();

    // flush while the fetch is in flight
    lat = 5; if_req = 1; if_addr = 32'h180;
    tick(); tick();
    if_flush = 1; if_req = 0;
    tick(); if_flush = 0;
    chk("t3_preq_c3", {31'b0, port_req}, 32'd1);
    tick(); tick();
    chk("t3_preq_c5", {31'b0, port_req}, 32'd1);
    chk("t3_addr_c5", port_addr, 32'h180);
    tick();
    chk("t3_preq_c6", {31'b0, port_req}, 32'd0);
    chk("t3_idone_c6", {31'b0, if_done}, 32'd0);
    lat = 1; if_req = 1; if_addr = 32'h200;
    tick();
    chk("t3_preq_c7", {31'b0, port_req}, 32'd1);
    chk("t3_addr_c7", port_addr, 32'h200);
    tick();
    chk("t3_idone_c8", {31'b0, if_done}, 32'd1);
    chk("t3_rdata_c8", if_rdata, 32'h0200_C0DE);
    tick(); if_req = 0;
    tick();

    // flush and ready in the same cycle
    lat = 3; if_req = 1; if_addr = 32'h300;
    tick(); tick(); tick();
    if_flush = 1; if_req = 0;
    chk("t4_preq_c3", {31'b0, port_req}, 32'd1);
    tick(); if_flush = 0;
    chk("t4_idone_c4", {31'b0, if_done}, 32'd0);
    chk("t4_rdata_kept", if_rdata, 32'h0200_C0DE);
    chk("t4_preq_c4", {31'b0, port_req}, 32'd0);
    tick(); tick();

    // load, then reset during the second BUSY_MEM cycle of another load
    lat = 1; mem_req = 1; mem_we = 0; mem_addr = 32'h440;
    tick(); tick();
    chk("t5_mdone", {31'b0, mem_done}, 32'd1);
    chk("t5_mrdata", mem_rdata, 32'h0440_C0DE);
    tick(); mem_addr = 32'h400; lat = 10;
    tick();
    chk("t5_preq_busy1", {31'b0, port_req}, 32'd1);
    chk("t5_addr_busy1", port_addr, 32'h400);
    tick();
    rstn = 0; mem_req = 0; if_req = 1; if_addr = 32'h500;
    tick();
    chk("t5_rst_preq", {31'b0, port_req}, 32'd0);
    chk("t5_rst_mdone", {31'b0, mem_done}, 32'd0);
    chk("t5_rst_mrdata", mem_rdata, 32'd0);
    chk("t5_rst_irdata", if_rdata, 32'd0);
    chk("t5_rst_addr", port_addr, 32'd0);
    rstn = 1; lat = 2;
    tick();
    chk("t5_preq_after", {31'b0, port_req}, 32'd1);
    chk("t5_addr_after", port_addr, 32'h500);
    tick(); tick();
    chk("t5_idone", {31'b0, if_done}, 32'd1);
    chk("t5_irdata", if_rdata, 32'h0500_C0DE);
    tick(); if_req = 0;
    tick();

    // zero-wait stream of four fetches
    lat = 1; a0 = acc_cnt; d0 = if_done_cnt; prev = 0;
    for (int i = 0; i < 4; i++) begin
      fa = 32'h600 + 32'(4 * i);
      if_req = 1; if_addr = fa;
      n = 0;
      while (if_done !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      if (n >= 10) chk("t6_timeout", {31'b0, if_done}, 32'd1);
      dcyc = cyc;
      chk("t6_rdata", if_rdata, rd_of(fa));
      chk("t6_last_addr", last_acc_addr, fa);
      chk("t6_access_cnt", acc_cnt - a0, 32'(i + 1));
      if (i > 0) chk("t6_spacing", 32'(dcyc - prev), 32'd3);
      prev = dcyc;
      tick();
    end
    if_req = 0;
    tick(); tick();
    chk("t6_done_pulses", if_done_cnt - d0, 32'd4);
    chk("t6_accesses", acc_cnt - a0, 32'd4);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
